uart_rx_cfg: RTL and testbench
==============================

Name: uart_rx_cfg

Overview:
Parametrised UART receiver, the successor to the fixed 8N1 receiver. It supports configurable data width, parity, stop bits and baud rate. Line sampling uses 16x oversampling with 3-sample majority vote and false-start rejection. Received words are buffered in a valid/ready holding register with parity, framing, break and overrun status, and the block feeds the command/FIFO logic behind the UART pin.

Parameters:
CLK_FREQ, 100_000_000, system clock in Hz
BAUDRATE, 9600, line rate in bit/s
DATA_BITS, 8, data bits per frame, legal 5..9
PARITY, 0, 0 none / 1 even / 2 odd
STOP_BITS, 1, legal 1 or 2

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low reset
rx  in  1  serial line, asynchronous, idle high
rx_ready  in  1  consumer accepts held word
rx_data  out  DATA_BITS  received word, LSB first on line
rx_valid  out  1  holding register full
parity_err  out  1  status of held word, parity mismatch
frame_err  out  1  status of held word, a stop bit sampled low
break_det  out  1  one-cycle pulse, break condition detected
overrun  out  1  one-cycle pulse, completed frame dropped
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (reset=0): all outputs 0; FSM to IDLE; counters 0; synchroniser flops set to 1. Reset mid-frame aborts the frame and leaves no partial data.
- Input path: 2-flop synchroniser on rx. All FSM decisions use the synchronised value rs.
- Tick: baud_gen pulses b_tick for 1 clk every F_COUNT = CLK_FREQ/(BAUDRATE*16) clks (651 at defaults). The counter is free-running from reset.
- Tick counter tc is 4 bits and counts b_ticks per bit, 0..15. Majority vote = 2 of 3 samples taken at tc = 7, 8, 9.
- FSM states:
  - IDLE: on b_tick with rs=0, go to START with tc=0.
  - START: at tc=9, if majority is 1, this is a false start: go to IDLE and report nothing. At tc=15, go to DATA with bit index 0.
  - DATA: at tc=9, shift the majority bit into the MSB of a DATA_BITS shift register (LSB-first reconstruction). At tc=15, advance. After DATA_BITS bits, go to PARITY if PARITY≠0, otherwise STOP.
  - PARITY: at tc=9, capture the bit; err_p = XOR(data, bit) ≠ (PARITY==2). At tc=15, go to STOP.
  - STOP: sample at tc=9. If STOP_BITS=2, the first stop bit waits for tc=15 and the second is sampled at its tc=9. Any low stop sample sets err_f. The frame completes at tc=9 of the last stop bit, which gives half a bit of resync margin.
  - WAIT_HIGH: stay until rs=1 on a b_tick, then go to IDLE.
- Frame completion:
  - Break: data all 0, parity sample 0 (if present) and err_f. Pulse break_det, do not load the holding register, go to WAIT_HIGH.
  - Else, if err_f, go to WAIT_HIGH after loading. Otherwise go to IDLE.
  - Load: if rx_valid=0, or rx_ready=1 in the same cycle, load rx_data, parity_err and frame_err and set rx_valid=1. Otherwise pulse overrun and keep the old word and status.
- Handshake: rx_valid stays high and rx_data/status stay stable until a cycle with rx_ready=1. That cycle clears rx_valid unless a new load occurs in the same cycle; a load wins and rx_valid stays 1.
- Latency: rx_valid rises 1 clk after the last-stop-bit tc=9 tick.
- busy=1 in every state except IDLE.

Decomposition:
- Shared package uart_pkg:
  - FSM state encoding: IDLE, START, DATA, PARITY, STOP, WAIT_HIGH (3 bits).
  - PAR_NONE/PAR_EVEN/PAR_ODD constants.
  - OVERSAMPLE=16, SAMPLE_LO=7, SAMPLE_HI=9.
- Sub-module baud_gen (CLK_FREQ, BAUDRATE, OVERSAMPLE): $clog2(F_COUNT)-wide counter producing b_tick. It replaces the fixed 9600 tick generator and is reused by the matching transmitter.

Test Plan:
1. Defaults (8N1), rx_ready=0, send 0xA5 -> rx_data=0xA5, rx_valid=1, no error flags; word held for 5 bit times; rx_ready=1 for one clk -> rx_valid=0 the next clk.
2. DATA_BITS=7, PARITY=1 (even): send 0x41 with parity bit 0 -> parity_err=0. Send 0x41 with parity bit 1 -> parity_err=1 and rx_data=0x41.
3. Glitches: rx low for 4 ticks (2604 clk) -> no rx_valid, busy returns to 0. Single-tick low pulse at tc=8 inside a 1 data bit of 0xFF -> rx_data=0xFF (majority vote).
4. Send 0x55 with stop bit driven 0, then rx high -> frame_err=1, rx_data=0x55, FSM waits in WAIT_HIGH until rx=1. Hold rx low for 20 bit times -> exactly one break_det pulse and no rx_valid.
5. Overrun and STOP_BITS=2: send 0x11 then 0x22 with rx_ready=0 -> rx_data stays 0x11, one overrun pulse at completion of the second frame. Second stop bit low -> frame_err=1.
6. Reset asserted mid-DATA of 0x3C -> all outputs 0 immediately. After release, send 0xC3 -> rx_data=0xC3, no error flags.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver FSM states, parity modes, oversampling points.
// Pure declarations, no logic and no latency.
// Not applicable (no handshake).
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_START     = 3'd1,
    ST_DATA      = 3'd2,
    ST_PARITY    = 3'd3,
    ST_STOP      = 3'd4,
    ST_WAIT_HIGH = 3'd5
  } uart_state_e;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  localparam int OVERSAMPLE = 16;
  localparam int SAMPLE_LO  = 7;
  localparam int SAMPLE_HI  = 9;

  // Two-out-of-three vote used to reject single-sample line noise.
  function automatic logic maj3(input logic a, input logic b, input logic c);
    return (a & b) | (a & c) | (b & c);
  endfunction

endpackage

// File: rtl/baud_gen.sv
// Oversampling tick generator: one-cycle b_tick_o every CLK_FREQ/(BAUDRATE*OVERSAMPLE) clocks.
// Free-running from reset, first tick F_COUNT clocks after reset release.
// No backpressure; consumers must act on the tick in the cycle it is high.
module baud_gen #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUDRATE   = 9600,
  parameter int OVERSAMPLE = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  output logic b_tick_o
);

  localparam int F_COUNT = CLK_FREQ / (BAUDRATE * OVERSAMPLE);
  localparam int CW      = (F_COUNT > 1) ? $clog2(F_COUNT) : 1;
  localparam logic [CW-1:0] LAST = CW'(F_COUNT - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  assign b_tick_o = (cnt_q == LAST);

  // Wrap the divider on every tick.
  always_comb begin
    cnt_d = b_tick_o ? '0 : cnt_q + CW'(1);
  end

  // Divider register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) cnt_q <= '0;
    else         cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver (5..9 data bits, none/even/odd parity, 1/2 stop) with 16x majority sampling.
// rx_valid rises 1 clk after the mid-point tick of the last stop bit.
// Single holding register; a frame completing while the word is still held is dropped with an overrun pulse.
module uart_rx_cfg
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 100_000_000,
  parameter int BAUDRATE  = 9600,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 rx,
  input  logic                 rx_ready,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_valid,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 overrun,
  output logic                 busy
);

  logic                 b_tick;
  logic                 rx_s1_q, rs_q;
  uart_state_e          state_q;
  logic [3:0]           tc_q;
  logic [3:0]           bit_idx_q;
  logic                 stop_idx_q;
  logic                 s7_q, s8_q;
  logic [DATA_BITS-1:0] shreg_q;
  logic                 par_bit_q, err_p_q, err_f_q;
  logic [DATA_BITS-1:0] rx_data_q;
  logic                 rx_valid_q, parity_err_q, frame_err_q, break_det_q, overrun_q;

  logic maj, at_mid, at_end, stop_f, is_break, last_stop, can_load, par_err_now;

  baud_gen #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUDRATE  (BAUDRATE),
    .OVERSAMPLE(OVERSAMPLE)
  ) u_baud_gen (
    .clk_i   (clk),
    .rst_ni  (reset),
    .b_tick_o(b_tick)
  );

  // Two-flop synchroniser; resets to the idle line level so reset never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx_s1_q <= 1'b1;
      rs_q    <= 1'b1;
    end else begin
      rx_s1_q <= rx;
      rs_q    <= rx_s1_q;
    end
  end

  // Sampling decisions and frame-completion qualifiers.
  always_comb begin
    maj         = maj3(s7_q, s8_q, rs_q);
    at_mid      = b_tick && (tc_q == 4'(SAMPLE_HI));
    at_end      = b_tick && (tc_q == 4'(OVERSAMPLE - 1));
    stop_f      = err_f_q | ~maj;
    last_stop   = (stop_idx_q == 1'(STOP_BITS - 1));
    is_break    = (shreg_q == '0) && ((PARITY == PAR_NONE) || !par_bit_q) && stop_f;
    can_load    = !rx_valid_q || rx_ready;
    par_err_now = ((^shreg_q) ^ maj) != (PARITY == PAR_ODD);
  end

  // Receive FSM with holding register and status outputs, all registered.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      tc_q         <= '0;
      bit_idx_q    <= '0;
      stop_idx_q   <= 1'b0;
      s7_q         <= 1'b1;
      s8_q         <= 1'b1;
      shreg_q      <= '0;
      par_bit_q    <= 1'b0;
      err_p_q      <= 1'b0;
      err_f_q      <= 1'b0;
      rx_data_q    <= '0;
      rx_valid_q   <= 1'b0;
      parity_err_q <= 1'b0;
      frame_err_q  <= 1'b0;
      break_det_q  <= 1'b0;
      overrun_q    <= 1'b0;
    end else begin
      break_det_q <= 1'b0;
      overrun_q   <= 1'b0;
      // Consumer takes the held word; a load later in this block overrides the clear.
      if (rx_ready) rx_valid_q <= 1'b0;

      if (b_tick) begin
        if (tc_q == 4'(SAMPLE_LO))     s7_q <= rs_q;
        if (tc_q == 4'(SAMPLE_LO + 1)) s8_q <= rs_q;
        tc_q <= tc_q + 4'd1;

        case (state_q)
          ST_IDLE: begin
            tc_q <= '0;
            if (!rs_q) begin
              state_q   <= ST_START;
              err_p_q   <= 1'b0;
              err_f_q   <= 1'b0;
              par_bit_q <= 1'b0;
            end
          end
          ST_START: begin
            if (at_mid && maj) begin
              state_q <= ST_IDLE;
            end else if (at_end) begin
              state_q   <= ST_DATA;
              bit_idx_q <= '0;
            end
          end
          ST_DATA: begin
            if (at_mid) shreg_q <= {maj, shreg_q[DATA_BITS-1:1]};
            if (at_end) begin
              if (bit_idx_q == 4'(DATA_BITS - 1)) begin
                state_q    <= (PARITY != PAR_NONE) ? ST_PARITY : ST_STOP;
                stop_idx_q <= 1'b0;
              end else begin
                bit_idx_q <= bit_idx_q + 4'd1;
              end
            end
          end
          ST_PARITY: begin
            if (at_mid) begin
              par_bit_q <= maj;
              err_p_q   <= par_err_now;
            end
            if (at_end) state_q <= ST_STOP;
          end
          ST_STOP: begin
            if (at_mid) begin
              if (last_stop) begin
                if (is_break) begin
                  break_det_q <= 1'b1;
                  state_q     <= ST_WAIT_HIGH;
                end else begin
                  if (can_load) begin
                    rx_data_q    <= shreg_q;
                    parity_err_q <= err_p_q;
                    frame_err_q  <= stop_f;
                    rx_valid_q   <= 1'b1;
                  end else begin
                    overrun_q <= 1'b1;
                  end
                  state_q <= stop_f ? ST_WAIT_HIGH : ST_IDLE;
                end
              end else begin
                err_f_q <= stop_f;
              end
            end else if (at_end) begin
              stop_idx_q <= 1'b1;
            end
          end
          ST_WAIT_HIGH: begin
            if (rs_q) state_q <= ST_IDLE;
          end
          default: state_q <= ST_IDLE;
        endcase
      end
    end
  end

  assign rx_data    = rx_data_q;
  assign rx_valid   = rx_valid_q;
  assign parity_err = parity_err_q;
  assign frame_err  = frame_err_q;
  assign break_det  = break_det_q;
  assign overrun    = overrun_q;
  assign busy       = (state_q != ST_IDLE);

endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: instance A is 8N1, instance B is 7 data bits, even parity, 2 stop bits.
// Both run at 4 clocks per oversample tick (64 clocks per bit) to keep runtime short.
// Frames are built from field values; expectations come from parity/stop/break rules.
module tb_uart_rx_cfg;

  localparam int CLK_FREQ = 1_000_000;
  localparam int BAUD     = 15_625;
  localparam int F        = 4;
  localparam int BIT      = 64;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       rx_a, rdy_a, vld_a, perr_a, ferr_a, brk_a, ovr_a, busy_a;
  logic [7:0] dat_a;
  logic       rx_b, rdy_b, vld_b, perr_b, ferr_b, brk_b, ovr_b, busy_b;
  logic [6:0] dat_b;

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .reset(reset), .rx(rx_a), .rx_ready(rdy_a), .rx_data(dat_a), .rx_valid(vld_a),
    .parity_err(perr_a), .frame_err(ferr_a), .break_det(brk_a), .overrun(ovr_a), .busy(busy_a));

  uart_rx_cfg #(.CLK_FREQ(CLK_FREQ), .BAUDRATE(BAUD), .DATA_BITS(7), .PARITY(1), .STOP_BITS(2)) dut_b (
    .clk(clk), .reset(reset), .rx(rx_b), .rx_ready(rdy_b), .rx_data(dat_b), .rx_valid(vld_b),
    .parity_err(perr_b), .frame_err(ferr_b), .break_det(brk_b), .overrun(ovr_b), .busy(busy_b));

  int checks = 0;
  int failures = 0;

  // Accepted words as {frame_err, parity_err, data[8:0]}, plus pulse counters.
  logic [10:0] q_a[$];
  logic [10:0] q_b[$];
  int brk_cnt_a = 0, brk_cnt_b = 0, ovr_cnt_a = 0, ovr_cnt_b = 0;

  always @(negedge clk) begin
    if (reset) begin
      if (vld_a && rdy_a) q_a.push_back({ferr_a, perr_a, 1'b0, dat_a});
      if (vld_b && rdy_b) q_b.push_back({ferr_b, perr_b, 2'b00, dat_b});
      if (brk_a) brk_cnt_a++;
      if (brk_b) brk_cnt_b++;
      if (ovr_a) ovr_cnt_a++;
      if (ovr_b) ovr_cnt_b++;
    end
  end

  task automatic wait_clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input bit w, input logic v);
    if (w) rx_b = v;
    else   rx_a = v;
  endtask

  task automatic set_rdy(input bit w, input logic v);
    if (w) rdy_b = v;
    else   rdy_a = v;
  endtask

  // Drive one frame; optional one-tick low glitch goff clocks into data bit gbit.
  task automatic send(input bit w, input logic [8:0] d, input int nb, input bit has_par,
                      input logic pbit, input logic [1:0] stops, input int ns,
                      input int gbit, input int goff);
    set_rx(w, 1'b0);
    wait_clks(BIT);
    for (int i = 0; i < nb; i++) begin
      set_rx(w, d[i]);
      if (i == gbit) begin
        wait_clks(goff);
        set_rx(w, 1'b0);
        wait_clks(F);
        set_rx(w, d[i]);
        wait_clks(BIT - goff - F);
      end else begin
        wait_clks(BIT);
      end
    end
    if (has_par) begin
      set_rx(w, pbit);
      wait_clks(BIT);
    end
    for (int s = 0; s < ns; s++) begin
      set_rx(w, stops[s]);
      wait_clks(BIT);
    end
    set_rx(w, 1'b1);
  endtask

  // Parity bit that makes the total number of ones even.
  function automatic logic even_bit(input logic [8:0] d, input int nb);
    logic p;
    p = 1'b0;
    for (int i = 0; i < nb; i++) p = p ^ d[i];
    return p;
  endfunction

  task automatic wait_valid(input bit w, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 4 * BIT; i++) begin
      if ((w ? vld_b : vld_a) === 1'b1) begin
        ok = 1'b1;
        break;
      end
      wait_clks(1);
    end
  endtask

  task automatic pop(input bit w);
    set_rdy(w, 1'b1);
    wait_clks(1);
    set_rdy(w, 1'b0);
  endtask

  task automatic test_reset;
    reset = 1'b0;
    wait_clks(3);
    checks++;
    if ({dat_a, vld_a, perr_a, ferr_a, brk_a, ovr_a, busy_a} !== 14'h0) begin
      failures++; $display("FAIL reset_a got=%h exp=0", {dat_a, vld_a, perr_a, ferr_a, brk_a, ovr_a, busy_a});
    end
    checks++;
    if ({dat_b, vld_b, perr_b, ferr_b, brk_b, ovr_b, busy_b} !== 13'h0) begin
      failures++; $display("FAIL reset_b got=%h exp=0", {dat_b, vld_b, perr_b, ferr_b, brk_b, ovr_b, busy_b});
    end
    reset = 1'b1;
    wait_clks(BIT);
  endtask

  task automatic test_basic;
    bit ok;
    rdy_a = 1'b0;
    send(1'b0, 9'h0A5, 8, 1'b0, 1'b0, 2'b11, 1, -1, 0);
    wait_valid(1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_timeout got=no_valid exp=valid"); end
    checks++;
    if ({dat_a, perr_a, ferr_a} !== {8'hA5, 2'b00}) begin
      failures++; $display("FAIL basic_word got=%h exp=%h", {dat_a, perr_a, ferr_a}, {8'hA5, 2'b00});
    end
    wait_clks(5 * BIT);
    checks++;
    if ({vld_a, dat_a} !== {1'b1, 8'hA5}) begin
      failures++; $display("FAIL basic_hold got=%h exp=%h", {vld_a, dat_a}, {1'b1, 8'hA5});
    end
    rdy_a = 1'b1;
    wait_clks(1);
    rdy_a = 1'b0;
    checks++;
    if (vld_a !== 1'b0) begin failures++; $display("FAIL basic_pop got=%b exp=0", vld_a); end
    q_a.delete();
  endtask

  task automatic test_parity;
    bit ok;
    rdy_b = 1'b0;
    for (int k = 0; k < 2; k++) begin
      send(1'b1, 9'h041, 7, 1'b1, logic'(k), 2'b11, 2, -1, 0);
      wait_valid(1'b1, ok);
      checks++;
      if (!ok) begin failures++; $display("FAIL parity_timeout k=%0d got=no_valid exp=valid", k); end
      checks++;
      if ({dat_b, perr_b, ferr_b} !== {7'h41, logic'(k), 1'b0}) begin
        failures++; $display("FAIL parity_word k=%0d got=%h exp=%h", k, {dat_b, perr_b, ferr_b}, {7'h41, logic'(k), 1'b0});
      end
      pop(1'b1);
    end
    q_b.delete();
  endtask

  task automatic test_glitch;
    logic [10:0] got;
    rdy_a = 1'b1;
    q_a.delete();
    rx_a = 1'b0;
    wait_clks(4 * F);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL glitch_busy got=%b exp=1", busy_a); end
    rx_a = 1'b1;
    wait_clks(2 * BIT);
    checks++;
    if ({busy_a, q_a.size() == 0} !== 2'b01) begin
      failures++; $display("FAIL glitch_false_start got=busy%b words%0d exp=busy0 words0", busy_a, q_a.size());
    end
    // Sweep a one-tick low pulse across the sample window of data bit 1.
    for (int k = 0; k < 5; k++) begin
      send(1'b0, 9'h0FF, 8, 1'b0, 1'b0, 2'b11, 1, 1, 30 + 4 * k);
      for (int t = 0; t < 32 && q_a.size() == 0; t++) wait_clks(1);
      got = (q_a.size() > 0) ? q_a.pop_front() : 11'bx;
      checks++;
      if (got !== 11'h0FF) begin failures++; $display("FAIL glitch_vote k=%0d got=%h exp=%h", k, got, 11'h0FF); end
    end
    rdy_a = 1'b0;
  endtask

  task automatic test_frame_break;
    bit ok;
    int b0;
    rdy_a = 1'b0;
    send(1'b0, 9'h055, 8, 1'b0, 1'b0, 2'b00, 1, -1, 0);
    rx_a = 1'b0;
    wait_valid(1'b0, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL ferr_timeout got=no_valid exp=valid"); end
    checks++;
    if ({dat_a, perr_a, ferr_a} !== {8'h55, 2'b01}) begin
      failures++; $display("FAIL ferr_word got=%h exp=%h", {dat_a, perr_a, ferr_a}, {8'h55, 2'b01});
    end
    wait_clks(2 * BIT);
    checks++;
    if (busy_a !== 1'b1) begin failures++; $display("FAIL ferr_wait_high got=%b exp=1", busy_a); end
    rx_a = 1'b1;
    wait_clks(BIT);
    checks++;
    if (busy_a !== 1'b0) begin failures++; $display("FAIL ferr_idle got=%b exp=0", busy_a); end
    pop(1'b0);
    b0 = brk_cnt_a;
    rx_a = 1'b0;
    wait_clks(20 * BIT);
    checks++;
    if ({busy_a, brk_cnt_a - b0} !== {1'b1, 32'd1}) begin
      failures++; $display("FAIL break_low got=busy%b pulses%0d exp=busy1 pulses1", busy_a, brk_cnt_a - b0);
    end
    rx_a = 1'b1;
    wait_clks(2 * BIT);
    checks++;
    if ({busy_a, vld_a, brk_cnt_a - b0} !== {2'b00, 32'd1}) begin
      failures++; $display("FAIL break_end got=busy%b vld%b pulses%0d exp=busy0 vld0 pulses1", busy_a, vld_a, brk_cnt_a - b0);
    end
    q_a.delete();
  endtask

  task automatic test_overrun;
    bit ok;
    int o0;
    rdy_b = 1'b0;
    o0 = ovr_cnt_b;
    send(1'b1, 9'h011, 7, 1'b1, even_bit(9'h011, 7), 2'b11, 2, -1, 0);
    wait_clks(4);
    checks++;
    if (ovr_cnt_b - o0 !== 0) begin failures++; $display("FAIL ovr_first got=%0d exp=0", ovr_cnt_b - o0); end
    send(1'b1, 9'h022, 7, 1'b1, even_bit(9'h022, 7), 2'b11, 2, -1, 0);
    wait_clks(4);
    checks++;
    if (ovr_cnt_b - o0 !== 1) begin failures++; $display("FAIL ovr_pulse got=%0d exp=1", ovr_cnt_b - o0); end
    checks++;
    if ({vld_b, dat_b, perr_b, ferr_b} !== {1'b1, 7'h11, 2'b00}) begin
      failures++; $display("FAIL ovr_keep got=%h exp=%h", {vld_b, dat_b, perr_b, ferr_b}, {1'b1, 7'h11, 2'b00});
    end
    pop(1'b1);
    send(1'b1, 9'h033, 7, 1'b1, even_bit(9'h033, 7), 2'b01, 2, -1, 0);
    wait_valid(1'b1, ok);
    checks++;
    if ({ok, dat_b, perr_b, ferr_b} !== {1'b1, 7'h33, 2'b01}) begin
      failures++; $display("FAIL stop2_ferr got=%h exp=%h", {ok, dat_b, perr_b, ferr_b}, {1'b1, 7'h33, 2'b01});
    end
    wait_clks(2 * BIT);
    checks++;
    if (busy_b !== 1'b0) begin failures++; $display("FAIL stop2_idle got=%b exp=0", busy_b); end
    pop(1'b1);
    q_b.delete();
  endtask

  // Random frames; gap_max=0 runs frames back to back except after a low stop bit.
  task automatic test_random(input bit w, input int n, input int gap_max);
    logic [8:0]  d;
    logic [1:0]  stops;
    logic [10:0] got, expv;
    logic        pbit, pflip, ferr_e, brk_e;
    int          nb, ns, b0, qs;
    nb = w ? 7 : 8;
    ns = w ? 2 : 1;
    set_rdy(w, 1'b1);
    if (w) q_b.delete(); else q_a.delete();
    for (int k = 0; k < n; k++) begin
      d = 9'($urandom) & ((9'h1 << nb) - 9'h1);
      if ($urandom_range(0, 5) == 0) d = '0;
      pflip = ($urandom_range(0, 3) == 0);
      pbit  = even_bit(d, nb) ^ pflip;
      stops = {logic'($urandom_range(0, 3) != 0), logic'($urandom_range(0, 3) != 0)};
      ferr_e = (stops[0] == 1'b0) || (ns == 2 && stops[1] == 1'b0);
      brk_e  = (d == 0) && (!w || pbit == 1'b0) && ferr_e;
      expv   = {ferr_e, w & pflip, d};
      b0 = w ? brk_cnt_b : brk_cnt_a;
      send(w, d, nb, w, pbit, stops, ns, -1, 0);
      for (int t = 0; t < 32; t++) begin
        qs = w ? q_b.size() : q_a.size();
        if (qs != 0 || (w ? brk_cnt_b : brk_cnt_a) != b0) break;
        wait_clks(1);
      end
      qs = w ? q_b.size() : q_a.size();
      if (brk_e) begin
        checks++;
        if ({qs == 0, (w ? brk_cnt_b : brk_cnt_a) - b0} !== {1'b1, 32'd1}) begin
          failures++; $display("FAIL rand_break dut%0d k=%0d got=words%0d pulses%0d exp=words0 pulses1",
                               w, k, qs, (w ? brk_cnt_b : brk_cnt_a) - b0);
        end
      end else begin
        if (qs > 0) got = w ? q_b.pop_front() : q_a.pop_front();
        else        got = 11'bx;
        checks++;
        if (got !== expv) begin
          failures++; $display("FAIL rand_word dut%0d k=%0d got=%h exp=%h", w, k, got, expv);
        end
      end
      if (ferr_e) wait_clks(2 * BIT);
      else if (gap_max > 0) wait_clks(BIT * $urandom_range(0, gap_max));
    end
    set_rdy(w, 1'b0);
  endtask

  task automatic test_back_to_back;
    test_random(1'b0, 6, 0);
    test_random(1'b1, 6, 0);
  endtask

  task automatic test_reset_mid;
    bit ok;
    logic [7:0] d;
    rdy_a = 1'b0;
    send(1'b0, 9'h05A, 8, 1'b0, 1'b0, 2'b11, 1, -1, 0);
    wait_valid(1'b0, ok);
    d = 8'h3C;
    rx_a = 1'b0;
    wait_clks(BIT);
    for (int i = 0; i < 4; i++) begin
      rx_a = d[i];
      wait_clks(i == 3 ? BIT / 2 : BIT);
    end
    reset = 1'b0;
    #1;
    checks++;
    if ({dat_a, vld_a, perr_a, ferr_a, brk_a, ovr_a, busy_a} !== 14'h0) begin
      failures++; $display("FAIL rst_mid_a got=%h exp=0", {dat_a, vld_a, perr_a, ferr_a, brk_a, ovr_a, busy_a});
    end
    rx_a = 1'b1;
    wait_clks(4);
    reset = 1'b1;
    wait_clks(2 * BIT);
    checks++;
    if ({vld_a, busy_a} !== 2'b00) begin
      failures++; $display("FAIL rst_mid_partial got=%b exp=00", {vld_a, busy_a});
    end
    send(1'b0, 9'h0C3, 8, 1'b0, 1'b0, 2'b11, 1, -1, 0);
    wait_valid(1'b0, ok);
    checks++;
    if ({ok, dat_a, perr_a, ferr_a} !== {1'b1, 8'hC3, 2'b00}) begin
      failures++; $display("FAIL rst_mid_after got=%h exp=%h", {ok, dat_a, perr_a, ferr_a}, {1'b1, 8'hC3, 2'b00});
    end
    pop(1'b0);
  endtask

  initial begin
    reset = 1'b0;
    rx_a  = 1'b1;
    rx_b  = 1'b1;
    rdy_a = 1'b0;
    rdy_b = 1'b0;
    test_reset;
    test_basic;
    test_parity;
    test_glitch;
    test_frame_break;
    test_overrun;
    test_random(1'b0, 8, 2);
    test_random(1'b1, 8, 2);
    test_back_to_back;
    test_reset_mid;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog got=running exp=finished");
    $fatal(1, "simulation time limit reached");
  end

endmodule
